// File: rtl/common_defines.sv
// common_defines: shared state encodings, fault codes and default timing constants for the flight loop sequencer
package common_defines;
  localparam int DEF_LOOP_PERIOD_US   = 2500;
  localparam int DEF_STAGE_TIMEOUT_US = 500;
  typedef enum logic [6:0] {
    IDLE      = 7'b0000001,
    WAIT_TICK = 7'b0000010,
    ANGLE     = 7'b0000100,
    RATE      = 7'b0001000,
    MIX       = 7'b0010000,
    DONE      = 7'b0100000,
    FAULT     = 7'b1000000
  } seq_state_e;
  typedef logic [1:0] fault_stage_t;
  localparam fault_stage_t FAULT_NONE  = 2'd0;
  localparam fault_stage_t FAULT_ANGLE = 2'd1;
  localparam fault_stage_t FAULT_RATE  = 2'd2;
  localparam fault_stage_t FAULT_MIXER = 2'd3;
endpackage

// File: rtl/loop_period_timer.sv
// loop_period_timer: free-running period counter held at zero while disabled, tick on the wrap cycle
module loop_period_timer
  import common_defines::*;
#(
  parameter int PERIOD = DEF_LOOP_PERIOD_US
) (
  input  logic us_clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick  = enable && cnt_q == LAST;
  assign cnt_d = (!enable || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge us_clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/flight_loop_sequencer.sv
// flight_loop_sequencer: ticks angle -> rate -> mixer stages once per period; FLIGHT_SEQ_TIMEOUT_EN adds per-stage timeout
module flight_loop_sequencer
  import common_defines::*;
#(
  parameter int LOOP_PERIOD_US   = DEF_LOOP_PERIOD_US,
  parameter int STAGE_TIMEOUT_US = DEF_STAGE_TIMEOUT_US
) (
  input  logic       us_clk,
  input  logic       resetn,
  input  logic       enable,
  output logic       angle_start,
  input  logic       angle_complete,
  output logic       rate_start,
  input  logic       rate_complete,
  output logic       mixer_start,
  input  logic       mixer_complete,
  output logic       loop_busy,
  output logic       loop_done,
  output logic [7:0] overrun_count,
  output logic       timeout_err,
  output logic [1:0] fault_stage
);
  seq_state_e state_q, state_d;
  logic angle_start_q, angle_start_d;
  logic rate_start_q, rate_start_d;
  logic mixer_start_q, mixer_start_d;
  logic [7:0] overrun_q, overrun_d;
  logic tick;

  if (LOOP_PERIOD_US < 2 || STAGE_TIMEOUT_US < 1) begin : g_bad_cfg
    $error("flight_loop_sequencer: need LOOP_PERIOD_US >= 2 and STAGE_TIMEOUT_US >= 1");
  end

  loop_period_timer #(.PERIOD(LOOP_PERIOD_US)) u_timer (
    .us_clk(us_clk),
    .resetn(resetn),
    .enable(enable),
    .tick  (tick)
  );

  assign angle_start   = angle_start_q;
  assign rate_start    = rate_start_q;
  assign mixer_start   = mixer_start_q;
  assign loop_busy     = state_q inside {ANGLE, RATE, MIX};
  assign loop_done     = state_q == DONE;
  assign overrun_count = overrun_q;
  // a tick that cannot launch a loop is counted and dropped
  assign overrun_d = (tick && state_q != WAIT_TICK && overrun_q != 8'hFF) ? overrun_q + 8'd1 : overrun_q;

`ifdef FLIGHT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(STAGE_TIMEOUT_US + 1);
  localparam logic [TW-1:0] STG_LAST = TW'(STAGE_TIMEOUT_US - 1);
  logic [TW-1:0] stg_cnt_q, stg_cnt_d;
  logic timeout_err_q, timeout_err_d;
  fault_stage_t fault_stage_q, fault_stage_d;
  logic stage_expired;
  assign stage_expired = loop_busy && stg_cnt_q == STG_LAST;
  assign timeout_err   = timeout_err_q;
  assign fault_stage   = fault_stage_q;
  always_ff @(posedge us_clk or negedge resetn)
    if (!resetn) begin
      stg_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      fault_stage_q <= FAULT_NONE;
    end else begin
      stg_cnt_q     <= stg_cnt_d;
      timeout_err_q <= timeout_err_d;
      fault_stage_q <= fault_stage_d;
    end
`else
  assign timeout_err = 1'b0;
  assign fault_stage = FAULT_NONE;
`endif

  // completes arriving in the same cycle as their start pulse are ignored
  always_comb begin
    state_d       = state_q;
    angle_start_d = 1'b0;
    rate_start_d  = 1'b0;
    mixer_start_d = 1'b0;
    unique case (state_q)
      IDLE:      if (enable) state_d = WAIT_TICK;
      WAIT_TICK: if (!enable) state_d = IDLE;
                 else if (tick) begin
                   state_d       = ANGLE;
                   angle_start_d = 1'b1;
                 end
      ANGLE:     if (!angle_start_q && angle_complete) begin
                   state_d      = RATE;
                   rate_start_d = 1'b1;
                 end
      RATE:      if (!rate_start_q && rate_complete) begin
                   state_d       = MIX;
                   mixer_start_d = 1'b1;
                 end
      MIX:       if (!mixer_start_q && mixer_complete) state_d = DONE;
      DONE:      state_d = enable ? WAIT_TICK : IDLE;
`ifdef FLIGHT_SEQ_TIMEOUT_EN
      FAULT:     if (!enable) state_d = IDLE;
`endif
      default:   state_d = IDLE;
    endcase
`ifdef FLIGHT_SEQ_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
    fault_stage_d = fault_stage_q;
    if (stage_expired && state_d == state_q) begin
      state_d       = FAULT;
      timeout_err_d = 1'b1;
      fault_stage_d = timeout_err_q ? fault_stage_q :
                      state_q == ANGLE ? FAULT_ANGLE : state_q == RATE ? FAULT_RATE : FAULT_MIXER;
    end
    stg_cnt_d = (loop_busy && state_d == state_q) ? stg_cnt_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge us_clk or negedge resetn)
    if (!resetn) begin
      state_q       <= IDLE;
      angle_start_q <= 1'b0;
      rate_start_q  <= 1'b0;
      mixer_start_q <= 1'b0;
      overrun_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      angle_start_q <= angle_start_d;
      rate_start_q  <= rate_start_d;
      mixer_start_q <= mixer_start_d;
      overrun_q     <= overrun_d;
    end
endmodule

// File: tb/tb_flight_loop_sequencer.sv
// tb_flight_loop_sequencer: random-delay stage responder checked against a tick-arithmetic model of the sequencer
module tb_flight_loop_sequencer;
  localparam int P = 100;
  localparam int T = 20;

  logic us_clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic [2:0] cpl = 3'b000;
  logic angle_start, rate_start, mixer_start, loop_busy, loop_done, timeout_err;
  logic [7:0] overrun_count;
  logic [1:0] fault_stage;
  logic [2:0] st;
  assign st = {mixer_start, rate_start, angle_start};

  flight_loop_sequencer #(.LOOP_PERIOD_US(P), .STAGE_TIMEOUT_US(T)) dut (
    .us_clk        (us_clk),
    .resetn        (resetn),
    .enable        (enable),
    .angle_start   (angle_start),
    .angle_complete(cpl[0]),
    .rate_start    (rate_start),
    .rate_complete (cpl[1]),
    .mixer_start   (mixer_start),
    .mixer_complete(cpl[2]),
    .loop_busy     (loop_busy),
    .loop_done     (loop_done),
    .overrun_count (overrun_count),
    .timeout_err   (timeout_err),
    .fault_stage   (fault_stage)
  );

  always #5 us_clk = ~us_clk;

  int cyc = 0;
  int na = 0, nm = 0, nd = 0;
  always @(posedge us_clk) cyc <= cyc + 1;
  always @(negedge us_clk) begin
    if (angle_start) na++;
    if (mixer_start) nm++;
    if (loop_done) nd++;
  end

  int n_chk = 0, n_pass = 0;
  int c0, exp_a, ovr_exp;
  bit en_on;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ticks fall on cycles c0+P-1, c0+2P-1, ... while enable stays high
  function automatic int ticks_le(input int x);
    int b;
    b = c0 + P - 1;
    return x < b ? 0 : (x - b) / P + 1;
  endfunction

  function automatic int next_angle(input int d);
    int b, j;
    b = c0 + P - 1;
    j = (d + 1 > b) ? (d + 1 - b + P - 1) / P : 0;
    return b + j * P + 1;
  endfunction

  task automatic start_enable();
    enable = 1'b1;
    en_on  = 1'b1;
    c0     = cyc;
    exp_a  = c0 + P;
  endtask

  task automatic wait_start(input int idx, input int bound, output int s);
    s = -1;
    for (int k = 0; k < bound && s < 0; k++) begin
      @(negedge us_clk);
      if (st[idx]) s = cyc;
    end
    check("start_seen", (s >= 0) ? 1 : 0, 1);
  endtask

  // called in the start cycle; returns one cycle after complete was presented
  task automatic stage(input int idx, input int d, input bit noise);
    cpl[idx] = noise;
    for (int k = 1; k <= d; k++) begin
      @(negedge us_clk);
      cpl[idx] = (k == d);
    end
    @(negedge us_clk);
    cpl[idx] = 1'b0;
  endtask

  task automatic run_loop(input int da, input int dr, input int dm, input bit noise, input bit drop);
    int s, d, nd0, n;
    wait_start(0, 2 * P + 50, s);
    check("angle_cyc", s, exp_a);
    check("angle_only", st, 3'b001);
    check("busy_angle", loop_busy, 1);
    nd0 = nd;
    if (drop) begin
      enable = 1'b0;
      en_on  = 1'b0;
    end
    stage(0, da, noise);
    check("rate_start", st, 3'b010);
    stage(1, dr, noise);
    check("mixer_start", st, 3'b100);
    stage(2, dm, noise);
    d = cyc;
    check("loop_done", loop_done, 1);
    check("busy_done", loop_busy, 0);
    if (en_on) begin
      n = ovr_exp + ticks_le(d) - ticks_le(s - 1);
      ovr_exp = n > 255 ? 255 : n;
      exp_a = next_angle(d);
    end
    @(negedge us_clk);
    check("overrun", overrun_count, ovr_exp);
    check("done_once", nd - nd0, 1);
    check("done_pulse", loop_done, 0);
  endtask

  initial begin
    int s, na0, nm0;
    ovr_exp = 0;
    en_on   = 1'b0;
    repeat (3) @(negedge us_clk);
    check("rst_starts", st, 0);
    check("rst_busy", loop_busy, 0);
    check("rst_done", loop_done, 0);
    check("rst_ovr", overrun_count, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_fstage", fault_stage, 0);
    resetn = 1'b1;
    repeat (3) @(negedge us_clk);
    check("idle_starts", st, 0);
    start_enable();
    run_loop(3, 3, 3, 1'b0, 1'b0);
    run_loop(3, 3, 3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      run_loop($urandom_range(1, 15), $urandom_range(1, 15), $urandom_range(1, 15), 1'($urandom_range(0, 1)), 1'b0);
`ifndef FLIGHT_SEQ_TIMEOUT_EN
    run_loop(3, 3, 150, 1'b0, 1'b0);
    run_loop(3, 3, 3, 1'b0, 1'b0);
`endif
    run_loop($urandom_range(1, 15), $urandom_range(1, 15), $urandom_range(1, 15), 1'b0, 1'b1);
    na0 = na;
    repeat (P + 20) @(negedge us_clk);
    check("no_restart", na - na0, 0);
    check("idle_busy", loop_busy, 0);
`ifndef FLIGHT_SEQ_TIMEOUT_EN
    start_enable();
    run_loop(3, 3, 25600, 1'b0, 1'b0);
`endif
    if (!enable) start_enable();
    wait_start(0, 2 * P + 50, s);
    check("angle_cyc_rst", s, exp_a);
    stage(0, 3, 1'b0);
    check("rate_before_rst", st, 3'b010);
    resetn = 1'b0;
    #1;
    check("arst_starts", st, 0);
    check("arst_busy", loop_busy, 0);
    check("arst_done", loop_done, 0);
    check("arst_ovr", overrun_count, 0);
    @(negedge us_clk);
    resetn  = 1'b1;
    c0      = cyc;
    exp_a   = c0 + P;
    ovr_exp = 0;
    @(negedge us_clk);
    check("post_rst_busy", loop_busy, 0);
    run_loop(3, 3, 3, 1'b0, 1'b0);
`ifdef FLIGHT_SEQ_TIMEOUT_EN
    wait_start(0, 2 * P + 50, s);
    check("angle_cyc_to", s, exp_a);
    stage(0, 3, 1'b0);
    check("rate_to", st, 3'b010);
    na0 = na;
    nm0 = nm;
    repeat (T - 1) @(negedge us_clk);
    check("busy_before_to", loop_busy, 1);
    check("terr_before_to", timeout_err, 0);
    @(negedge us_clk);
    check("busy_fault", loop_busy, 0);
    check("terr_fault", timeout_err, 1);
    check("fstage_fault", fault_stage, 2);
    repeat (2 * P) @(negedge us_clk);
    check("no_mixer", nm - nm0, 0);
    check("no_angle_fault", na - na0, 0);
    enable = 1'b0;
    repeat (3) @(negedge us_clk);
    check("terr_kept", timeout_err, 1);
    check("fstage_kept", fault_stage, 2);
    start_enable();
    wait_start(0, 2 * P + 50, s);
    check("angle_after_fault", s, exp_a);
    check("terr_sticky", timeout_err, 1);
`else
    run_loop(3, 40, 3, 1'b0, 1'b0);
    check("no_terr", timeout_err, 0);
    check("no_fstage", fault_stage, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
